// File: rtl/pam_modulator_if.sv
// AXI-Stream word channel carrying packed PAM symbols into the modulator.
interface pam_modulator_if #(
    parameter int unsigned WIDTH_AXI_DATA = 32
);
    logic                          tvalid;
    logic                          tready;
    logic [WIDTH_AXI_DATA-1:0]     tdata;
    logic [WIDTH_AXI_DATA/8-1:0]   tkeep;
    logic                          tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/pam_modulator.sv
// PAM transmit framer: pilot burst, packed data symbols (MSB nibble first), then a silent gap.
// One DAC code per clock; words are pulled from AXI-Stream only in their scheduled cycle.
module pam_modulator #(
    parameter int unsigned AD_CVER_WIDTH  = 12,
    parameter int unsigned LENGTH_DATA    = 1024,
    parameter int unsigned LENGTH_PILOT   = 4,
    parameter int unsigned LENGTH_GAP     = 16,
    parameter int unsigned PAM_ORDER      = 4,
    parameter int unsigned WIDTH_AXI_DATA = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pam_modulator_if.slave           s_axi,
    output logic                     mod_da_valid,
    output logic [AD_CVER_WIDTH-1:0] mod_da_data,
    output logic                     err_underrun,
    output logic                     err_tlast
);

    localparam int unsigned SymPerWord    = WIDTH_AXI_DATA / PAM_ORDER;
    localparam int unsigned SymIdxW       = $clog2(SymPerWord);
    localparam int unsigned WordsPerFrame = LENGTH_DATA / SymPerWord;
    localparam int unsigned CntMax0       = (LENGTH_DATA > LENGTH_GAP) ? LENGTH_DATA : LENGTH_GAP;
    localparam int unsigned CntMax        = (CntMax0 > LENGTH_PILOT) ? CntMax0 : LENGTH_PILOT;
    localparam int unsigned CntW          = $clog2(CntMax + 1);
    localparam int unsigned WIdxW         = CntW - SymIdxW;
    // Equal level spacing across the full DAC range: 4095/15 = 273 for the default widths.
    localparam int unsigned Step          = ((2 ** AD_CVER_WIDTH) - 1) / ((2 ** PAM_ORDER) - 1);

    localparam logic [CntW-1:0]    PilotLast = CntW'(LENGTH_PILOT - 1);
    localparam logic [CntW-1:0]    DataLast  = CntW'(LENGTH_DATA - 1);
    localparam logic [CntW-1:0]    GapLast   = CntW'(LENGTH_GAP - 1);
    localparam logic [SymIdxW-1:0] SymLast   = SymIdxW'(SymPerWord - 1);
    localparam logic [WIdxW-1:0]   WordLast  = WIdxW'(WordsPerFrame - 1);
    localparam logic [AD_CVER_WIDTH-1:0] MidCode = {1'b1, {(AD_CVER_WIDTH - 1){1'b0}}};

    // Unsigned level minus half scale: flipping the MSB yields the two's complement code.
    function automatic logic [AD_CVER_WIDTH-1:0] sym_to_code(input logic [PAM_ORDER-1:0] nib);
        logic [AD_CVER_WIDTH-1:0] lvl;
        lvl = AD_CVER_WIDTH'(Step * 32'(nib));
        return lvl ^ MidCode;
    endfunction

    localparam logic [AD_CVER_WIDTH-1:0] PilotCode = sym_to_code({PAM_ORDER{1'b1}});

    typedef enum logic [1:0] {StIdle, StPilot, StData, StGap} state_e;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [WIDTH_AXI_DATA-1:0] shift_q, shift_d;
    logic                      zero_q, zero_d;
    logic                      mod_da_valid_q, mod_da_valid_d;
    logic [AD_CVER_WIDTH-1:0]  mod_da_data_q, mod_da_data_d;
    logic                      err_underrun_q, err_underrun_d;
    logic                      err_tlast_q, err_tlast_d;

    logic                      sched;
    logic                      hs;
    logic                      emit;
    logic [WIdxW-1:0]          word_idx;
    logic [PAM_ORDER-1:0]      cur_nib;

    logic unused_tkeep;
    assign unused_tkeep = ^s_axi.tkeep;

    // Scheduling: one word fetch in the cycle before its first sample.
    always_comb begin
        sched = ((state_q == StPilot) && (cnt_q == PilotLast)) ||
                ((state_q == StData) && (cnt_q[SymIdxW-1:0] == SymLast) && (cnt_q != DataLast));
        hs    = sched && s_axi.tvalid;
        emit  = ((state_q == StPilot) && (cnt_q == PilotLast)) ||
                ((state_q == StData) && (cnt_q != DataLast));
        word_idx = (state_q == StPilot) ? '0 : (cnt_q[CntW-1:SymIdxW] + WIdxW'(1));
        cur_nib  = hs ? s_axi.tdata[WIDTH_AXI_DATA-1 -: PAM_ORDER]
                      : shift_q[WIDTH_AXI_DATA-1 -: PAM_ORDER];
    end

    assign s_axi.tready = sched;

    // Frame sequencing and next-cycle output values.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        zero_d         = zero_q;
        mod_da_valid_d = 1'b0;
        mod_da_data_d  = '0;
        err_underrun_d = sched && !s_axi.tvalid;
        err_tlast_d    = hs && (s_axi.tlast != (word_idx == WordLast));

        if (emit) begin
            if (sched) begin
                // A missing word still occupies its slot, sent as mid-scale silence.
                shift_d = s_axi.tvalid ? (s_axi.tdata << PAM_ORDER) : '0;
                zero_d  = !s_axi.tvalid;
            end else begin
                shift_d = shift_q << PAM_ORDER;
            end
            mod_da_valid_d = 1'b1;
            mod_da_data_d  = zero_d ? '0 : sym_to_code(cur_nib);
        end

        unique case (state_q)
            StIdle: begin
                if (s_axi.tvalid) begin
                    state_d        = StPilot;
                    cnt_d          = '0;
                    mod_da_valid_d = 1'b1;
                    mod_da_data_d  = PilotCode;
                end
            end
            StPilot: begin
                if (cnt_q == PilotLast) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else begin
                    cnt_d          = cnt_q + CntW'(1);
                    mod_da_valid_d = 1'b1;
                    mod_da_data_d  = PilotCode;
                end
            end
            StData: begin
                if (cnt_q == DataLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            shift_q        <= '0;
            zero_q         <= 1'b0;
            mod_da_valid_q <= 1'b0;
            mod_da_data_q  <= '0;
            err_underrun_q <= 1'b0;
            err_tlast_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            zero_q         <= zero_d;
            mod_da_valid_q <= mod_da_valid_d;
            mod_da_data_q  <= mod_da_data_d;
            err_underrun_q <= err_underrun_d;
            err_tlast_q    <= err_tlast_d;
        end
    end

    assign mod_da_valid = mod_da_valid_q;
    assign mod_da_data  = mod_da_data_q;
    assign err_underrun = err_underrun_q;
    assign err_tlast    = err_tlast_q;

endmodule

// File: tb/tb_pam_modulator.sv
// Scoreboard bench for pam_modulator: the driver queues expected DAC codes per frame,
// the monitor pops one per valid output sample.
module tb_pam_modulator;

    localparam int P = 4;
    localparam int D = 1024;
    localparam int G = 16;
    localparam int W = 128;
    localparam logic [31:0] WordLo = 32'h0123_4567;
    localparam logic [31:0] WordHi = 32'hFEDC_BA98;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mod_da_valid;
    logic [11:0] mod_da_data;
    logic        err_underrun;
    logic        err_tlast;

    pam_modulator_if #(.WIDTH_AXI_DATA(32)) axi ();

    pam_modulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axi        (axi),
        .mod_da_valid (mod_da_valid),
        .mod_da_data  (mod_da_data),
        .err_underrun (err_underrun),
        .err_tlast    (err_tlast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;
    int err_u_cnt = 0;
    int err_t_cnt = 0;
    int err_u_cyc = -1;

    // Hand-computed codes for the two test words, nibble order [31:28] first.
    logic [11:0] lo_tab [8] = '{12'h800, 12'h911, 12'hA22, 12'hB33,
                                12'hC44, 12'hD55, 12'hE66, 12'hF77};
    logic [11:0] hi_tab [8] = '{12'h7FF, 12'h6EE, 12'h5DD, 12'h4CC,
                                12'h3BB, 12'h2AA, 12'h199, 12'h088};

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic bit use_hi(input int mode, input int k);
        return (mode == 1) || (mode == 2 && (k % 2) == 1);
    endfunction

    function automatic logic [31:0] word_of(input int mode, input int k);
        return use_hi(mode, k) ? WordHi : WordLo;
    endfunction

    function automatic logic tlast_of(input int mode, input int k);
        return (mode == 3) ? (k == 63) : (k == W - 1);
    endfunction

    // Monitor: every valid sample must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mod_da_valid) begin
                if (exp_q.size() == 0) begin
                    check("expected_sample_available", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("da_sample", int'(mod_da_data), int'(mon_e));
                end
            end
            if (err_underrun) begin
                err_u_cnt++;
                err_u_cyc = cyc;
            end
            if (err_tlast) err_t_cnt++;
        end
    end

    task automatic push_frame(input int mode, input int n_data);
        repeat (P) exp_q.push_back(12'h7FF);
        for (int n = 0; n < n_data; n++) begin
            int k;
            int i;
            k = n / 8;
            i = n % 8;
            if (mode == 2 && k == 5) exp_q.push_back(12'h000);
            else if (use_hi(mode, k)) exp_q.push_back(hi_tab[i]);
            else exp_q.push_back(lo_tab[i]);
        end
    endtask

    // Present word k and wait (bounded) for its tready pulse; check the pulse cycle.
    task automatic handshake(input int mode, input int k, input int t0);
        bit seen;
        seen = 1'b0;
        axi.tvalid = !(mode == 2 && k == 5);
        axi.tdata  = word_of(mode, k);
        axi.tlast  = tlast_of(mode, k);
        for (int w = 0; w < 16 && !seen; w++) begin
            @(negedge clk);
            if (k == 0 && cyc == t0 + 1) begin
                check("first_pilot_valid", int'(mod_da_valid), 1);
                check("first_pilot_code", int'(mod_da_data), 12'h7FF);
            end
            if (axi.tready) seen = 1'b1;
        end
        check("tready_seen", int'(seen), 1);
        if (seen) check("tready_cycle", cyc, t0 + P + 8 * k);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int mode, input int t0_in, input bit b2b, output int t0);
        err_u_cnt = 0;
        err_t_cnt = 0;
        err_u_cyc = -1;
        push_frame(mode, D);
        if (t0_in < 0) begin
            @(posedge clk);
            #1;
            t0 = cyc;
        end else begin
            t0 = t0_in;
        end
        for (int k = 0; k < W; k++) handshake(mode, k, t0);
        if (b2b) begin
            axi.tvalid = 1'b1;
            axi.tdata  = WordLo;
            axi.tlast  = 1'b0;
        end else begin
            axi.tvalid = 1'b0;
        end
        while (cyc < t0 + P + D + 1) begin
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < G; g++) begin
            @(negedge clk);
            check("gap_valid", int'(mod_da_valid), 0);
            check("gap_data", int'(mod_da_data), 0);
        end
        check("queue_drained", exp_q.size(), 0);
        check("err_underrun_count", err_u_cnt, (mode == 2) ? 1 : 0);
        check("err_tlast_count", err_t_cnt, (mode == 3) ? 2 : 0);
        if (mode == 2) check("err_underrun_cycle", err_u_cyc, t0 + P + 40 + 1);
        if (!b2b) begin
            @(negedge clk);
            check("idle_tready", int'(axi.tready), 0);
            check("idle_valid", int'(mod_da_valid), 0);
        end
    endtask

    // Reset in the middle of data sample 300, then a clean frame.
    task automatic run_abort();
        int t0;
        int t1;
        push_frame(0, 300);
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int k = 0; k < 38; k++) handshake(0, k, t0);
        while (cyc < t0 + P + 1 + 300) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_valid", int'(mod_da_valid), 0);
        check("abort_data", int'(mod_da_data), 0);
        check("abort_tready", int'(axi.tready), 0);
        check("abort_err_underrun", int'(err_underrun), 0);
        check("abort_err_tlast", int'(err_tlast), 0);
        check("abort_queue", exp_q.size(), 0);
        axi.tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run_frame(1, -1, 1'b0, t1);
    endtask

    initial begin
        int t;
        int t_next;
        axi.tvalid = 1'b0;
        axi.tdata  = '0;
        axi.tkeep  = '1;
        axi.tlast  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(mod_da_valid), 0);
        check("rst_data", int'(mod_da_data), 0);
        check("rst_tready", int'(axi.tready), 0);
        check("rst_err_underrun", int'(err_underrun), 0);
        check("rst_err_tlast", int'(err_tlast), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("hold_idle_tready", int'(axi.tready), 0);
            check("hold_idle_valid", int'(mod_da_valid), 0);
        end
        @(posedge clk);
        #1;
        run_frame(0, -1, 1'b0, t);
        run_frame(1, -1, 1'b0, t);
        run_frame(2, -1, 1'b0, t);
        run_frame(3, -1, 1'b1, t);
        run_frame(0, t + P + D + G + 1, 1'b0, t_next);
        run_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
